// File: rtl/bit_deserializer.sv
// Serial-to-parallel word assembler with a one-word output register, valid/ready handoff and a sticky drop flag.
// Latency: a word is on data_out one cycle after its last bit is sampled. When the consumer stalls, a word that completes while one is still held is dropped and raises overflow.
module bit_deserializer #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       bit_in,
  input  logic                       bit_en,
  output logic [WIDTH-1:0]           data_out,
  output logic                       data_valid,
  input  logic                       data_ready,
  output logic                       overflow,
  input  logic                       clr_ovf,
  output logic                       busy,
  output logic [$clog2(WIDTH+1)-1:0] bit_cnt
);

  localparam int CW = $clog2(WIDTH+1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_nxt;
  logic             last;
  logic             drop;

  // The first accepted bit is walked toward the chosen end of the word.
  always_comb begin
    sr_nxt = sr;
    if (MSB_FIRST != 0) sr_nxt = {sr[WIDTH-2:0], bit_in};
    else                sr_nxt = {bit_in, sr[WIDTH-1:1]};
  end

  assign last = bit_en && (bit_cnt == CW'(WIDTH-1));
  assign drop = last && data_valid && !data_ready;
  assign busy = (state == SHIFT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sr         <= '0;
      bit_cnt    <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (bit_en) begin
        if (last) begin
          state   <= IDLE;
          sr      <= '0;
          bit_cnt <= '0;
        end else begin
          state   <= SHIFT;
          sr      <= sr_nxt;
          bit_cnt <= bit_cnt + CW'(1);
        end
      end

      // A completing word may replace the held one only if that one leaves on this edge.
      if (last && (!data_valid || data_ready)) begin
        data_out   <= sr_nxt;
        data_valid <= 1'b1;
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end

      if (drop)         overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bit_deserializer.sv
// Directed bench: an MSB-first and an LSB-first instance share one stimulus stream.
module tb_bit_deserializer;

  logic       clk = 1'b0;
  logic       rst, bit_in, bit_en, data_ready, clr_ovf;
  logic [7:0] data_out,  l_data_out;
  logic       data_valid, l_data_valid;
  logic       overflow,   l_overflow;
  logic       busy,       l_busy;
  logic [3:0] bit_cnt,    l_bit_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bit_deserializer #(.WIDTH(8), .MSB_FIRST(1)) dut (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_en(bit_en),
    .data_out(data_out), .data_valid(data_valid), .data_ready(data_ready),
    .overflow(overflow), .clr_ovf(clr_ovf), .busy(busy), .bit_cnt(bit_cnt)
  );

  bit_deserializer #(.WIDTH(8), .MSB_FIRST(0)) dut_lsb (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_en(bit_en),
    .data_out(l_data_out), .data_valid(l_data_valid), .data_ready(data_ready),
    .overflow(l_overflow), .clr_ovf(clr_ovf), .busy(l_busy), .bit_cnt(l_bit_cnt)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Sends w[7] first; optional ready/clear pulses ride on the final bit.
  task automatic send_word(input logic [7:0] w, input logic rdy_last, input logic clr_last);
    for (int i = 7; i >= 0; i--) begin
      bit_in     = w[i];
      bit_en     = 1'b1;
      data_ready = (i == 0) ? rdy_last : 1'b0;
      clr_ovf    = (i == 0) ? clr_last : 1'b0;
      cyc();
    end
    bit_en     = 1'b0;
    data_ready = 1'b0;
    clr_ovf    = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; bit_in = 1'b0; bit_en = 1'b0; data_ready = 1'b0; clr_ovf = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
    checks++;
    if ({data_out, data_valid, overflow, busy, bit_cnt} !== 15'd0) begin
      errors++; $display("FAIL reset_outputs got %h exp 0", {data_out, data_valid, overflow, busy, bit_cnt});
    end
  endtask

  task automatic test_msb_first();
    logic [7:0] w;
    w = 8'hD0;
    bit_in = w[7]; bit_en = 1'b1;
    cyc();
    checks++;
    if (busy !== 1'b1 || bit_cnt !== 4'd1) begin
      errors++; $display("FAIL first_bit busy=%b cnt=%0d exp busy=1 cnt=1", busy, bit_cnt);
    end
    bit_en = 1'b0;
    cyc(); cyc();
    checks++;
    if (busy !== 1'b1 || bit_cnt !== 4'd1) begin
      errors++; $display("FAIL hold_no_en busy=%b cnt=%0d exp busy=1 cnt=1", busy, bit_cnt);
    end
    for (int i = 6; i >= 0; i--) begin
      bit_in = w[i]; bit_en = 1'b1;
      cyc();
      if (i == 1) begin
        checks++;
        if (data_valid !== 1'b0 || bit_cnt !== 4'd7) begin
          errors++; $display("FAIL seventh_bit valid=%b cnt=%0d exp valid=0 cnt=7", data_valid, bit_cnt);
        end
      end
    end
    bit_en = 1'b0;
    checks++;
    if (data_out !== 8'hD0 || data_valid !== 1'b1) begin
      errors++; $display("FAIL msb_word data=%h valid=%b exp D0 1", data_out, data_valid);
    end
    checks++;
    if (busy !== 1'b0 || bit_cnt !== 4'd0) begin
      errors++; $display("FAIL msb_done busy=%b cnt=%0d exp 0 0", busy, bit_cnt);
    end
    checks++;
    if (l_data_out !== 8'h0B || l_data_valid !== 1'b1) begin
      errors++; $display("FAIL lsb_word data=%h valid=%b exp 0B 1", l_data_out, l_data_valid);
    end
    data_ready = 1'b1;
    cyc();
    checks++;
    if (data_valid !== 1'b0 || l_data_valid !== 1'b0) begin
      errors++; $display("FAIL consume valid=%b/%b exp 0/0", data_valid, l_data_valid);
    end
    cyc();
    data_ready = 1'b0;
    checks++;
    if (data_valid !== 1'b0 || data_out !== 8'hD0) begin
      errors++; $display("FAIL ready_idle valid=%b data=%h exp 0 D0", data_valid, data_out);
    end
  endtask

  task automatic test_lsb_toggle();
    logic [7:0] w;
    w = 8'hD0;
    for (int i = 7; i >= 0; i--) begin
      bit_in = w[i]; bit_en = 1'b1;
      cyc();
      bit_en = 1'b0; bit_in = ~w[i];
      if (i == 0) begin
        checks++;
        if (l_data_out !== 8'h0B || l_data_valid !== 1'b1) begin
          errors++; $display("FAIL lsb_toggle data=%h valid=%b exp 0B 1", l_data_out, l_data_valid);
        end
        checks++;
        if (data_out !== 8'hD0 || data_valid !== 1'b1) begin
          errors++; $display("FAIL msb_toggle data=%h valid=%b exp D0 1", data_out, data_valid);
        end
      end
      cyc();
      if (i == 1) begin
        checks++;
        if (l_data_valid !== 1'b0 || l_bit_cnt !== 4'd7) begin
          errors++; $display("FAIL toggle_seven valid=%b cnt=%0d exp 0 7", l_data_valid, l_bit_cnt);
        end
      end
    end
  endtask

  task automatic test_overflow();
    send_word(8'hFF, 1'b0, 1'b0);
    checks++;
    if (overflow !== 1'b1 || l_overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_set ovf=%b/%b exp 1/1", overflow, l_overflow);
    end
    checks++;
    if (data_out !== 8'hD0 || data_valid !== 1'b1) begin
      errors++; $display("FAIL ovf_keep data=%h valid=%b exp D0 1", data_out, data_valid);
    end
    cyc();
    checks++;
    if (overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_sticky ovf=%b exp 1", overflow);
    end
    data_ready = 1'b1;
    cyc();
    data_ready = 1'b0;
    checks++;
    if (data_valid !== 1'b0 || overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_consume valid=%b ovf=%b exp 0 1", data_valid, overflow);
    end
    clr_ovf = 1'b1;
    cyc();
    clr_ovf = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      errors++; $display("FAIL ovf_clear ovf=%b exp 0", overflow);
    end
  endtask

  task automatic test_back_to_back();
    send_word(8'hD0, 1'b0, 1'b0);
    send_word(8'h5A, 1'b1, 1'b0);
    checks++;
    if (data_out !== 8'h5A || data_valid !== 1'b1 || overflow !== 1'b0) begin
      errors++; $display("FAIL b2b data=%h valid=%b ovf=%b exp 5A 1 0", data_out, data_valid, overflow);
    end
    checks++;
    if (l_data_out !== 8'h5A || l_overflow !== 1'b0) begin
      errors++; $display("FAIL b2b_lsb data=%h ovf=%b exp 5A 0", l_data_out, l_overflow);
    end
  endtask

  task automatic test_set_wins();
    send_word(8'h33, 1'b0, 1'b1);
    checks++;
    if (overflow !== 1'b1 || data_out !== 8'h5A) begin
      errors++; $display("FAIL set_wins ovf=%b data=%h exp 1 5A", overflow, data_out);
    end
    clr_ovf = 1'b1; data_ready = 1'b1;
    cyc();
    clr_ovf = 1'b0; data_ready = 1'b0;
    checks++;
    if (overflow !== 1'b0 || data_valid !== 1'b0) begin
      errors++; $display("FAIL clear_after ovf=%b valid=%b exp 0 0", overflow, data_valid);
    end
  endtask

  task automatic test_reset_abort();
    send_word(8'hC3, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      bit_in = 1'b1; bit_en = 1'b1;
      cyc();
    end
    checks++;
    if (bit_cnt !== 4'd5 || busy !== 1'b1) begin
      errors++; $display("FAIL partial cnt=%0d busy=%b exp 5 1", bit_cnt, busy);
    end
    rst = 1'b1; bit_en = 1'b1; data_ready = 1'b1; clr_ovf = 1'b1;
    cyc();
    rst = 1'b0; bit_en = 1'b0; data_ready = 1'b0; clr_ovf = 1'b0;
    checks++;
    if ({data_out, data_valid, overflow, busy, bit_cnt} !== 15'd0) begin
      errors++; $display("FAIL rst_abort got %h exp 0", {data_out, data_valid, overflow, busy, bit_cnt});
    end
    for (int i = 0; i < 3; i++) begin
      bit_in = 1'b1; bit_en = 1'b1;
      cyc();
    end
    bit_en = 1'b0;
    checks++;
    if (data_valid !== 1'b0 || bit_cnt !== 4'd3) begin
      errors++; $display("FAIL rst_count valid=%b cnt=%0d exp 0 3", data_valid, bit_cnt);
    end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    send_word(8'h81, 1'b0, 1'b0);
    checks++;
    if (data_out !== 8'h81 || data_valid !== 1'b1 || l_data_out !== 8'h81) begin
      errors++; $display("FAIL post_rst data=%h/%h valid=%b exp 81/81 1", data_out, l_data_out, data_valid);
    end
  endtask

  initial begin
    test_reset();
    test_msb_first();
    test_lsb_toggle();
    test_overflow();
    test_back_to_back();
    test_set_wins();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
